// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch stage's hazard/redirect inputs, its instruction
// memory port and its IF/ID outputs.
//
// Handshake: there is no back-pressure on this bus. iRdEn marks a cycle in
// which the stage consumes iData, and iData must be valid in that same cycle
// because it is a combinational read of iAddr. valid marks IF/ID as holding
// a real fetched instruction; when valid is low, IF/ID holds a bubble.
//
// Modports:
//   master - used by fetch_stage (drives iAddr, iRdEn and the IF/ID outputs)
//   slave  - used by the environment (drives stall, redirect, redirectPC, iData)
interface fetch_if #(
  parameter int PC_W = 16
);
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirectPC;
  logic [PC_W-1:0] iAddr;
  logic            iRdEn;
  logic [15:0]     iData;
  logic [15:0]     instr;
  logic [PC_W-1:0] pcPlus1;
  logic            valid;
  logic            halted;

  modport master (
    input  stall, redirect, redirectPC, iData,
    output iAddr, iRdEn, instr, pcPlus1, valid, halted
  );

  modport slave (
    output stall, redirect, redirectPC, iData,
    input  iAddr, iRdEn, instr, pcPlus1, valid, halted
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch plus IF/ID pipeline register.
// Owns the PC, presents it as the instruction-memory address and registers
// the fetched word for decode. Supports hazard stalls, redirect with flush,
// and freezing fetch after a HLT is fetched.
//
// Ports:
//   clk      - clock; all state updates on the rising edge
//   rst      - synchronous, active-high reset
//   bus      - fetch_if.master (stall/redirect/redirectPC/iData in;
//              iAddr/iRdEn/instr/pcPlus1/valid/halted out)
//   stateDbg - current FSM state (0 = FETCH, 1 = HALT)
//
// Edge priority: rst > redirect > stall > halted > normal fetch.
module fetch_stage #(
  parameter int              PC_W       = 16,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [15:0]     NOP_INSTR  = 16'h0000,
  parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
  input  logic     clk,
  input  logic     rst,
  fetch_if.master  bus,
  output logic     stateDbg
);

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } state_e;

  state_e          stateQ;
  state_e          stateD;
  logic [PC_W-1:0] pcQ;
  logic [15:0]     instrQ;
  logic [PC_W-1:0] pcPlus1Q;
  logic            validQ;

  logic            isHlt;
  logic            doFetch;
  logic            doBubble;

  assign isHlt = (bus.iData[15:12] == HLT_OPCODE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) stateQ <= FETCH;
    else     stateQ <= stateD;
  end

  // Next state. A redirect always returns to FETCH: a halt that was fetched
  // down a mispredicted path must not freeze the machine.
  always_comb begin
    stateD = stateQ;
    if (bus.redirect) begin
      stateD = FETCH;
    end else if (!bus.stall && (stateQ == FETCH) && isHlt) begin
      stateD = HALT;
    end
  end

  // Output/control decode. doFetch already excludes rst, so it doubles as the
  // memory read enable.
  always_comb begin
    doFetch  = !rst && !bus.redirect && !bus.stall && (stateQ == FETCH);
    doBubble = !bus.redirect && !bus.stall && (stateQ == HALT);
  end

  // PC and IF/ID register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcQ      <= RESET_PC;
      instrQ   <= NOP_INSTR;
      pcPlus1Q <= '0;
      validQ   <= 1'b0;
    end else if (bus.redirect) begin
      // Flush; pcPlus1 is left as-is since the bubble never uses it.
      pcQ    <= bus.redirectPC;
      instrQ <= NOP_INSTR;
      validQ <= 1'b0;
    end else if (doFetch) begin
      instrQ   <= bus.iData;
      pcPlus1Q <= pcQ + PC_W'(1);
      validQ   <= 1'b1;
      // The PC parks on the HLT so that a later redirect is the only way out.
      if (!isHlt) pcQ <= pcQ + PC_W'(1);
    end else if (doBubble) begin
      instrQ <= NOP_INSTR;
      validQ <= 1'b0;
    end
  end

  assign bus.iAddr   = pcQ;
  assign bus.iRdEn   = doFetch;
  assign bus.instr   = instrQ;
  assign bus.pcPlus1 = pcPlus1Q;
  assign bus.valid   = validQ;
  assign bus.halted  = (stateQ == HALT);
  assign stateDbg    = stateQ;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.PC_W(16)) bus  ();
  fetch_if #(.PC_W(16)) bus2 ();
  logic stateDbg, stateDbg2;

  fetch_stage #(.PC_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.master), .stateDbg(stateDbg)
  );

  fetch_stage #(.PC_W(16), .RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .rst(rst2), .bus(bus2.master), .stateDbg(stateDbg2)
  );

  // ---------------- instruction memory ----------------
  logic [15:0] imem [0:65535];
  assign bus.iData  = imem[bus.iAddr];
  assign bus2.iData = imem[bus2.iAddr];

  // ---------------- scoreboard counters ----------------
  int passCnt  = 0;
  int totalCnt = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        expRdEn;   // combinational, before the edge
    logic [15:0] expInstr;  // registered, after the edge
    logic [15:0] expP1;
    logic        expValid;
    logic        expHalted;
    logic [15:0] expAddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic s, input logic rd,
                              input logic [15:0] rpc, input logic en,
                              input logic [15:0] ins, input logic [15:0] p1,
                              input logic v, input logic h, input logic [15:0] a);
    vec_t t;
    t.rst = r; t.stall = s; t.redirect = rd; t.rpc = rpc; t.expRdEn = en;
    t.expInstr = ins; t.expP1 = p1; t.expValid = v; t.expHalted = h; t.expAddr = a;
    return t;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
    rst = r;
    bus.stall = s;
    bus.redirect = rd;
    bus.redirectPC = rpc;
  endtask

  // ---------------- behavioural reference ----------------
  logic [15:0] mPc, mInstr, mP1;
  logic        mValid, mHalted;

  task automatic modelReset();
    mPc = 16'h0000; mInstr = NOP; mP1 = 16'h0000; mValid = 1'b0; mHalted = 1'b0;
  endtask

  task automatic modelStep(input logic r, input logic s, input logic rd, input logic [15:0] rpc);
    logic [15:0] w;
    if (r) begin
      modelReset();
    end else if (rd) begin
      mPc = rpc; mInstr = NOP; mValid = 1'b0; mHalted = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (mHalted) begin
      mInstr = NOP; mValid = 1'b0;
    end else begin
      w = imem[mPc];
      mInstr = w; mP1 = mPc + 16'd1; mValid = 1'b1;
      if (w[15:12] == 4'hF) mHalted = 1'b1;
      else mPc = mPc + 16'd1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic r, s, rd;
    logic [15:0] rpc;

    for (int a = 0; a < 65536; a++) imem[a] = 16'($urandom_range(0, 65535));
    imem[0] = 16'h1123; imem[1] = 16'h2456; imem[2] = 16'h3789; imem[3] = 16'h4ABC;
    imem[4] = 16'h5111; imem[5] = 16'hF000;
    imem[16'h0010] = 16'h7010; imem[16'h0011] = 16'h7011;
    imem[16'h0040] = 16'h6040; imem[16'h0041] = 16'h6041;
    imem[16'hFFFF] = 16'h8FFF;

    drive(1'b1, 1'b0, 1'b0, 16'h0000);
    bus2.stall = 1'b0; bus2.redirect = 1'b0; bus2.redirectPC = 16'h0000;

    // reset, sequential fetch, stall, halt, redirect out of halt,
    // redirect+stall, reset mid-stall-and-redirect
    vecs.push_back(mk(1,0,0,16'h0000, 0, NOP,16'h0000,0,0,16'h0000));
    vecs.push_back(mk(1,0,0,16'h0000, 0, NOP,16'h0000,0,0,16'h0000));
    vecs.push_back(mk(0,0,0,16'h0000, 1, 16'h1123,16'h0001,1,0,16'h0001));
    vecs.push_back(mk(0,0,0,16'h0000, 1, 16'h2456,16'h0002,1,0,16'h0002));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0,1,0,16'h0000, 0, 16'h2456,16'h0002,1,0,16'h0002));
    vecs.push_back(mk(0,0,0,16'h0000, 1, 16'h3789,16'h0003,1,0,16'h0003));
    vecs.push_back(mk(0,0,0,16'h0000, 1, 16'h4ABC,16'h0004,1,0,16'h0004));
    vecs.push_back(mk(0,0,0,16'h0000, 1, 16'h5111,16'h0005,1,0,16'h0005));
    vecs.push_back(mk(0,0,0,16'h0000, 1, 16'hF000,16'h0006,1,1,16'h0005));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(0,0,0,16'h0000, 0, NOP,16'h0006,0,1,16'h0005));
    vecs.push_back(mk(0,0,1,16'h0010, 0, NOP,16'h0006,0,0,16'h0010));
    vecs.push_back(mk(0,0,0,16'h0000, 1, 16'h7010,16'h0011,1,0,16'h0011));
    vecs.push_back(mk(0,1,1,16'h0040, 0, NOP,16'h0011,0,0,16'h0040));
    vecs.push_back(mk(0,0,0,16'h0000, 1, 16'h6040,16'h0041,1,0,16'h0041));
    vecs.push_back(mk(0,1,0,16'h0000, 0, 16'h6040,16'h0041,1,0,16'h0041));
    vecs.push_back(mk(1,1,1,16'h0040, 0, NOP,16'h0000,0,0,16'h0000));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
      #2;
      chk($sformatf("v%0d iRdEn", i), 16'(bus.iRdEn), 16'(vecs[i].expRdEn));
      @(posedge clk); #1;
      chk($sformatf("v%0d instr", i),   bus.instr,         vecs[i].expInstr);
      chk($sformatf("v%0d pcPlus1", i), bus.pcPlus1,       vecs[i].expP1);
      chk($sformatf("v%0d valid", i),   16'(bus.valid),    16'(vecs[i].expValid));
      chk($sformatf("v%0d halted", i),  16'(bus.halted),   16'(vecs[i].expHalted));
      chk($sformatf("v%0d iAddr", i),   bus.iAddr,         vecs[i].expAddr);
    end

    // Randomized run against the reference model; the table ended in reset.
    modelReset();
    for (int n = 0; n < 2000; n++) begin
      r  = ($urandom_range(0, 49) == 0);
      s  = ($urandom_range(0, 4) == 0);
      rd = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7))
                                        : 16'($urandom_range(0, 255));
      drive(r, s, rd, rpc);
      #2;
      chk("rnd iRdEn", 16'(bus.iRdEn), 16'(!(r || s || rd || mHalted)));
      chk("rnd iAddr pre", bus.iAddr, mPc);
      modelStep(r, s, rd, rpc);
      @(posedge clk); #1;
      chk("rnd instr",   bus.instr,       mInstr);
      chk("rnd pcPlus1", bus.pcPlus1,     mP1);
      chk("rnd valid",   16'(bus.valid),  16'(mValid));
      chk("rnd halted",  16'(bus.halted), 16'(mHalted));
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0000);

    // RESET_PC override: wrap from 0xFFFF to 0x0000.
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("r6 reset iAddr", bus2.iAddr, 16'hFFFF);
    chk("r6 reset valid", 16'(bus2.valid), 16'h0000);
    rst2 = 1'b0;
    #2;
    chk("r6 iRdEn", 16'(bus2.iRdEn), 16'h0001);
    @(posedge clk); #1;
    chk("r6 instr",   bus2.instr,   16'h8FFF);
    chk("r6 pcPlus1", bus2.pcPlus1, 16'h0000);
    chk("r6 iAddr",   bus2.iAddr,   16'h0000);
    chk("r6 valid",   16'(bus2.valid), 16'h0001);
    @(posedge clk); #1;
    chk("r6 instr2",   bus2.instr,   16'h1123);
    chk("r6 pcPlus1b", bus2.pcPlus1, 16'h0001);
    chk("r6 iAddr2",   bus2.iAddr,   16'h0001);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
